// File: rtl/countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_pkg
// Shared definitions for the MM:SS countdown timer.
//   - bcd_t      : one 4-bit BCD digit
//   - state_t    : controller states IDLE / RUN / PAUSE / DONE
//   - ONES_MAX   : largest value of a ones digit (9)
//   - TENS_MAX   : largest value of a tens digit (5, minutes and seconds both)
//   - bcd_clamp  : saturate a digit to its limit so a register never holds
//                  a value outside the legal range for its position
// -----------------------------------------------------------------------------
package countdown_timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_t ONES_MAX = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;

  // Saturate a preset digit to the limit of its position.
  function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t limit);
    bcd_t r;
    if (d > limit) begin
      r = limit;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One registered BCD digit that counts down and wraps from 0 to its limit.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, clears Q to 0
//   load   in   load D (saturated to limit) into Q; has priority over dec
//   dec    in   decrement Q, 0 wraps to limit
//   limit  in   [3:0] largest legal value of this digit (9 or 5)
//   D      in   [3:0] preset value
//   Q      out  [3:0] current digit (registered)
//   hit0   out  Q == 0; the parent uses it to gate the borrow into the
//               next more significant digit
// -----------------------------------------------------------------------------
module bcd_down_digit
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] limit,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       hit0
);

  bcd_t r_q;

  // Digit register: reset > load > decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 4'd0;
    end else if (load) begin
      r_q <= bcd_clamp(D, limit);
    end else if (dec) begin
      if (r_q == 4'd0) begin
        r_q <= limit;
      end else begin
        r_q <= r_q - 4'd1;
      end
    end else begin
      r_q <= r_q;
    end
  end

  assign Q    = r_q;
  assign hit0 = (r_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// MM:SS BCD countdown timer (max 59:59) with start / pause / cancel / alarm.
// Ports:
//   clk                 in   system clock, all state on rising edge
//   reset               in   synchronous active-high reset
//   tick                in   1 Hz one-cycle enable, counts one second in RUN
//   set                 in   load preset new_* (IDLE or PAUSE only)
//   start               in   enter RUN from IDLE/PAUSE when time is nonzero
//   stop                in   RUN->PAUSE, PAUSE->clear+IDLE, DONE->IDLE
//   new_min_t/min_o/sec_t/sec_o  in [3:0]  preset digits, clamped on load
//   min_t/min_o/sec_t/sec_o      out [3:0] current time, registered
//   running             out  high while in RUN
//   expired             out  one-cycle pulse when the count reaches 00:00
//   ring                out  high while in DONE
// Exactly one input is acted on per cycle, chosen by priority
// reset > stop > set > start > tick; lower-priority inputs asserted in the
// same cycle are discarded, even if the winning input has no effect.
// -----------------------------------------------------------------------------
module countdown_timer
  import countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       set,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] new_min_t,
  input  logic [3:0] new_min_o,
  input  logic [3:0] new_sec_t,
  input  logic [3:0] new_sec_o,
  output logic [3:0] min_t,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       expired,
  output logic       ring
);

  state_t r_state;
  logic   r_running;
  logic   r_expired;
  logic   r_ring;

  state_t w_state_next;
  logic   w_load;
  logic   w_clear;
  logic   w_dec;
  logic   w_expire;
  logic   w_time_zero;
  logic   w_time_one;
  logic   w_hit0_so;
  logic   w_hit0_st;
  logic   w_hit0_mo;
  logic   w_hit0_mt;
  logic   w_dec_so;
  logic   w_dec_st;
  logic   w_dec_mo;
  logic   w_dec_mt;
  bcd_t   w_d_min_t;
  bcd_t   w_d_min_o;
  bcd_t   w_d_sec_t;
  bcd_t   w_d_sec_o;

  // Zero / one-second detection on the registered digits.
  always_comb begin
    w_time_zero = w_hit0_so & w_hit0_st & w_hit0_mo & w_hit0_mt;
    w_time_one  = (sec_o == 4'd1) & w_hit0_st & w_hit0_mo & w_hit0_mt;
  end

  // Next-state and digit-control decode with strict input priority.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_dec        = 1'b0;
    w_expire     = 1'b0;
    if (stop) begin
      case (r_state)
        RUN:   w_state_next = PAUSE;
        PAUSE: begin
          w_load       = 1'b1;
          w_clear      = 1'b1;
          w_state_next = IDLE;
        end
        DONE:  w_state_next = IDLE;
        IDLE:  w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end else if (set) begin
      if ((r_state == IDLE) || (r_state == PAUSE)) begin
        w_load = 1'b1;
      end else begin
        w_load = 1'b0;
      end
    end else if (start) begin
      if (((r_state == IDLE) || (r_state == PAUSE)) && !w_time_zero) begin
        w_state_next = RUN;
      end else begin
        w_state_next = r_state;
      end
    end else if (tick) begin
      // RUN always leaves at 00:01, so the zero guard only protects against
      // an underflow that should be unreachable.
      if ((r_state == RUN) && !w_time_zero) begin
        w_dec = 1'b1;
        if (w_time_one) begin
          w_state_next = DONE;
          w_expire     = 1'b1;
        end else begin
          w_state_next = r_state;
        end
      end else begin
        w_dec = 1'b0;
      end
    end else begin
      w_state_next = r_state;
    end
  end

  // Preset data: zeros when cancelling from PAUSE, else the new_* inputs.
  always_comb begin
    if (w_clear) begin
      w_d_min_t = 4'd0;
      w_d_min_o = 4'd0;
      w_d_sec_t = 4'd0;
      w_d_sec_o = 4'd0;
    end else begin
      w_d_min_t = new_min_t;
      w_d_min_o = new_min_o;
      w_d_sec_t = new_sec_t;
      w_d_sec_o = new_sec_o;
    end
  end

  // Borrow ripple: a digit steps only when every lower digit is at zero.
  always_comb begin
    w_dec_so = w_dec;
    w_dec_st = w_dec_so & w_hit0_so;
    w_dec_mo = w_dec_st & w_hit0_st;
    w_dec_mt = w_dec_mo & w_hit0_mo;
  end

  bcd_down_digit u_sec_o (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec_so),
    .limit (ONES_MAX),
    .D     (w_d_sec_o),
    .Q     (sec_o),
    .hit0  (w_hit0_so)
  );

  bcd_down_digit u_sec_t (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec_st),
    .limit (TENS_MAX),
    .D     (w_d_sec_t),
    .Q     (sec_t),
    .hit0  (w_hit0_st)
  );

  bcd_down_digit u_min_o (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec_mo),
    .limit (ONES_MAX),
    .D     (w_d_min_o),
    .Q     (min_o),
    .hit0  (w_hit0_mo)
  );

  bcd_down_digit u_min_t (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .dec   (w_dec_mt),
    .limit (TENS_MAX),
    .D     (w_d_min_t),
    .Q     (min_t),
    .hit0  (w_hit0_mt)
  );

  // Controller state and registered status outputs, decoded from next state
  // so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_ring    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN);
      r_expired <= w_expire;
      r_ring    <= (w_state_next == DONE);
    end
  end

  assign running = r_running;
  assign expired = r_expired;
  assign ring    = r_ring;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Directed self-checking bench for countdown_timer. Each check compares the
// packed time {min_t,min_o,sec_t,sec_o} and flags {running,expired,ring}
// one cycle after the stimulus edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       set;
  logic       start;
  logic       stop;
  logic [3:0] new_min_t;
  logic [3:0] new_min_o;
  logic [3:0] new_sec_t;
  logic [3:0] new_sec_o;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       expired;
  logic       ring;

  logic [15:0] obs_time;
  logic [2:0]  obs_flags;

  int n_vec;
  int n_miss;

  // Control vector bits: {reset, stop, set, start, tick}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_TICK  = 5'b00001;
  localparam logic [4:0] C_START = 5'b00010;
  localparam logic [4:0] C_SET   = 5'b00100;
  localparam logic [4:0] C_STOP  = 5'b01000;
  localparam logic [4:0] C_RESET = 5'b10000;

  countdown_timer dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .set       (set),
    .start     (start),
    .stop      (stop),
    .new_min_t (new_min_t),
    .new_min_o (new_min_o),
    .new_sec_t (new_sec_t),
    .new_sec_o (new_sec_o),
    .min_t     (min_t),
    .min_o     (min_o),
    .sec_t     (sec_t),
    .sec_o     (sec_o),
    .running   (running),
    .expired   (expired),
    .ring      (ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs_time  = {min_t, min_o, sec_t, sec_o};
  assign obs_flags = {running, expired, ring};

  // Apply one cycle of control inputs, then sample 1 time unit after the edge.
  task automatic drive(input logic [4:0] ctl);
    {reset, stop, set, start, tick} = ctl;
    @(posedge clk);
    #1;
    {reset, stop, set, start, tick} = 5'b00000;
  endtask

  task automatic preset(input logic [3:0] mt, input logic [3:0] mo,
                        input logic [3:0] st, input logic [3:0] so);
    new_min_t = mt;
    new_min_o = mo;
    new_sec_t = st;
    new_sec_o = so;
  endtask

  // Reference: seconds remaining to packed BCD MM:SS.
  function automatic logic [15:0] bcd_of(input int s);
    int m;
    int x;
    logic [15:0] r;
    m = s / 60;
    x = s % 60;
    r[15:12] = 4'(m / 10);
    r[11:8]  = 4'(m % 10);
    r[7:4]   = 4'(x / 10);
    r[3:0]   = 4'(x % 10);
    return r;
  endfunction

  task automatic test_reset();
    preset(4'd1, 4'd2, 4'd3, 4'd4);
    drive(C_RESET | C_SET | C_START);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL reset_state: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
  endtask

  task automatic test_one_minute();
    drive(C_RESET);
    preset(4'd0, 4'd1, 4'd0, 4'd0);
    drive(C_SET);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0100, 3'b000}) begin
      n_miss++;
      $display("FAIL set_0100: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0100, 3'b000);
    end
    drive(C_START);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0100, 3'b100}) begin
      n_miss++;
      $display("FAIL start_0100: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0100, 3'b100);
    end
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0059, 3'b100}) begin
      n_miss++;
      $display("FAIL tick_0059: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0059, 3'b100);
    end
  endtask

  task automatic test_expire();
    drive(C_RESET);
    preset(4'd0, 4'd0, 4'd0, 4'd2);
    drive(C_SET);
    drive(C_START);
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0001, 3'b100}) begin
      n_miss++;
      $display("FAIL exp_tick1: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0001, 3'b100);
    end
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b011}) begin
      n_miss++;
      $display("FAIL exp_tick2: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b011);
    end
    drive(C_NONE);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b001}) begin
      n_miss++;
      $display("FAIL exp_pulse_end: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b001);
    end
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b001}) begin
      n_miss++;
      $display("FAIL exp_no_wrap: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b001);
    end
  endtask

  task automatic test_pause_cancel();
    drive(C_RESET);
    preset(4'd1, 4'd0, 4'd0, 4'd0);
    drive(C_SET);
    drive(C_START);
    drive(C_STOP | C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h1000, 3'b000}) begin
      n_miss++;
      $display("FAIL pause_hold: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h1000, 3'b000);
    end
    drive(C_STOP);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL pause_cancel: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
    drive(C_START);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL cancel_start_zero: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
  endtask

  task automatic test_borrow_resume();
    drive(C_RESET);
    preset(4'd2, 4'd0, 4'd0, 4'd0);
    drive(C_SET);
    drive(C_START);
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h1959, 3'b100}) begin
      n_miss++;
      $display("FAIL borrow_full: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h1959, 3'b100);
    end
    preset(4'd0, 4'd5, 4'd0, 4'd0);
    drive(C_SET);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h1959, 3'b100}) begin
      n_miss++;
      $display("FAIL set_in_run: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h1959, 3'b100);
    end
    drive(C_STOP);
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h1959, 3'b000}) begin
      n_miss++;
      $display("FAIL tick_in_pause: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h1959, 3'b000);
    end
    drive(C_START);
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h1958, 3'b100}) begin
      n_miss++;
      $display("FAIL resume_tick: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h1958, 3'b100);
    end
  endtask

  task automatic test_clamp();
    drive(C_RESET);
    preset(4'd7, 4'd15, 4'd9, 4'd12);
    drive(C_SET);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h5959, 3'b000}) begin
      n_miss++;
      $display("FAIL clamp_all: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h5959, 3'b000);
    end
    preset(4'd7, 4'd0, 4'd1, 4'd12);
    drive(C_SET);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h5019, 3'b000}) begin
      n_miss++;
      $display("FAIL clamp_mixed: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h5019, 3'b000);
    end
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h5019, 3'b000}) begin
      n_miss++;
      $display("FAIL tick_in_idle: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h5019, 3'b000);
    end
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    drive(C_SET);
    drive(C_START);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL start_at_zero: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(C_RESET);
    preset(4'd0, 4'd0, 4'd0, 4'd1);
    drive(C_SET);
    drive(C_START);
    drive(C_RESET | C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL reset_with_tick: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL reset_no_expire: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
  endtask

  task automatic test_done_ack();
    drive(C_RESET);
    preset(4'd0, 4'd0, 4'd0, 4'd1);
    drive(C_SET);
    drive(C_START);
    drive(C_TICK);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b011}) begin
      n_miss++;
      $display("FAIL done_enter: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b011);
    end
    preset(4'd0, 4'd5, 4'd0, 4'd0);
    drive(C_SET);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b001}) begin
      n_miss++;
      $display("FAIL set_in_done: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b001);
    end
    drive(C_STOP);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0000, 3'b000}) begin
      n_miss++;
      $display("FAIL done_stop: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0000, 3'b000);
    end
    preset(4'd0, 4'd3, 4'd0, 4'd0);
    drive(C_SET);
    drive(C_STOP);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0300, 3'b000}) begin
      n_miss++;
      $display("FAIL stop_in_idle: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0300, 3'b000);
    end
    drive(C_START);
    n_vec++;
    if ({obs_time, obs_flags} !== {16'h0300, 3'b100}) begin
      n_miss++;
      $display("FAIL idle_start: got %h/%b expected %h/%b", obs_time, obs_flags, 16'h0300, 3'b100);
    end
  endtask

  task automatic test_full_countdown();
    logic [15:0] exp_time;
    logic [2:0]  exp_flags;
    drive(C_RESET);
    preset(4'd0, 4'd2, 4'd0, 4'd5);
    drive(C_SET);
    drive(C_START);
    for (int i = 1; i <= 125; i++) begin
      drive(C_TICK);
      exp_time  = bcd_of(125 - i);
      exp_flags = (i == 125) ? 3'b011 : 3'b100;
      n_vec++;
      if ({obs_time, obs_flags} !== {exp_time, exp_flags}) begin
        n_miss++;
        $display("FAIL countdown_step%0d: got %h/%b expected %h/%b", i, obs_time, obs_flags, exp_time, exp_flags);
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    {reset, stop, set, start, tick} = 5'b00000;
    preset(4'd0, 4'd0, 4'd0, 4'd0);
    test_reset();
    test_one_minute();
    test_expire();
    test_pause_cancel();
    test_borrow_resume();
    test_clamp();
    test_reset_mid_run();
    test_done_ack();
    test_full_countdown();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
